alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter BITS, default 32, operand width.
REQ-002 Parameter SIG_COUNT, default 12, ALU one-hot control width.
REQ-003 Parameter MULDIV_LAT, default 4, cycles ctrl held for multiply/divide (legal range 1-15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 clr  in  1  reset, synchronous, active-high.
REQ-006 op_valid  in  1  operation request.
REQ-007 op_ready  out  1  controller can accept an operation.
REQ-008 opcode  in  4  ALU op index: 0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not; 12-15 illegal.
REQ-009 a_in, b_in  in  BITS each  operands, sampled at acceptance.
REQ-010 alu_ctrl  out  SIG_COUNT  one-hot ALU control, bit index = opcode.
REQ-011 alu_x, alu_y  out  BITS each  registered operands driven to the ALU.
REQ-012 alu_result  in  2*BITS  ALU result.
REQ-013 res_valid  out  1  z_hi/z_lo/res_err valid.
REQ-014 res_ready  in  1  consumer accepts result.
REQ-015 z_hi, z_lo  out  BITS each  captured result, upper/lower halves.
REQ-016 res_err  out  1  result invalid (illegal opcode or divide by zero), qualified by res_valid.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, HOLD; op_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur on a cycle with op_valid=1 and op_ready=1; op_valid outside IDLE SHALL be ignored.
REQ-019 On legal acceptance (except div with b_in=0): alu_x<=a_in, alu_y<=b_in, alu_ctrl<=one-hot(opcode), count<=lat-1, IDLE->EXEC.
REQ-020 lat SHALL be MULDIV_LAT for opcodes 2,3 and 1 for all others.
REQ-021 In EXEC, count SHALL decrement each cycle; when count=0: z_hi<=alu_result[2*BITS-1:BITS], z_lo<=alu_result[BITS-1:0], res_err<=0, alu_ctrl<=0, EXEC->HOLD.
REQ-022 Latency: accept at cycle T -> alu_ctrl nonzero exactly cycles T+1..T+lat, res_valid first high at T+lat+1.
REQ-023 Illegal opcode or opcode 3 with b_in=0: alu_ctrl SHALL stay 0, z_hi=z_lo=0, res_err<=1, IDLE->HOLD directly (res_valid at T+1).
REQ-024 res_valid SHALL be 1 exactly in HOLD; z_hi, z_lo, res_err SHALL be stable while res_valid=1 and res_ready=0.
REQ-025 HOLD with res_ready=1 SHALL return to IDLE next cycle; res_ready while res_valid=0 SHALL have no effect.
REQ-026 alu_x/alu_y SHALL hold their values until the next legal acceptance.
REQ-027 alu_ctrl SHALL never have more than one bit set.

Reset
REQ-028 clr=1 at a rising edge SHALL force state IDLE, count=0, alu_ctrl=0, alu_x=alu_y=0, z_hi=z_lo=0, res_err=0, res_valid=0, op_ready=1 from the next cycle.
REQ-029 clr SHALL override any in-flight operation (EXEC or HOLD); the aborted result SHALL be discarded and no acceptance SHALL occur in a clr cycle.

Structure
REQ-030 A shared package alu_ctrl_pkg SHALL hold opcode constants (OP_ADD..OP_NOT), OP_COUNT=12, and the state encoding.
REQ-031 One sub-module, onehot_decoder (opcode -> SIG_COUNT one-hot, zero for illegal), SHALL be instantiated; all other logic resides in alu_issue_ctrl.

Verification
REQ-032 add: opcode 0, a=5, b=7, ALU model returns 12 -> alu_ctrl=0x001 for one cycle, res_valid at T+2, z_hi=0, z_lo=12, res_err=0.
REQ-033 mul: opcode 2, a=0x10000, b=0x10000, MULDIV_LAT=4 -> alu_ctrl=0x004 for cycles T+1..T+4, res_valid at T+5, z_hi=1, z_lo=0.
REQ-034 div by zero: opcode 3, b=0 -> alu_ctrl stays 0, res_valid at T+1, res_err=1, z_hi=z_lo=0; illegal opcode 13 -> same response.
REQ-035 backpressure: res_ready=0 for 10 cycles after res_valid -> outputs stable, op_ready=0, second op_valid ignored; res_ready=1 -> IDLE next cycle, then second op accepted.
REQ-036 reset mid-op: clr=1 at T+2 of a mul -> next cycle all outputs at reset values, op_ready=1, no res_valid for aborted op.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcode constants and FSM encoding for the ALU issue controller
// Purpose: opcode indices (bit position in the one-hot ALU control), number of
//          legal opcodes, controller state encoding and a latency helper.
// Ports:   none (package).
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam int OP_COUNT = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Multiply and divide are the only multi-cycle operations.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - operation/result handshake and ALU-facing bus of the issue controller
// Purpose: groups every non-clock signal of alu_issue_ctrl.
// Ports:   slave  - the controller (accepts ops, drives ALU controls and results)
//          master - the environment (issues ops, models the ALU, consumes results)
interface alu_issue_ctrl_if #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12
);

  logic                   op_valid;
  logic                   op_ready;
  logic [3:0]             opcode;
  logic [BITS-1:0]        a_in;
  logic [BITS-1:0]        b_in;
  logic [SIG_COUNT-1:0]   alu_ctrl;
  logic [BITS-1:0]        alu_x;
  logic [BITS-1:0]        alu_y;
  logic [2*BITS-1:0]      alu_result;
  logic                   res_valid;
  logic                   res_ready;
  logic [BITS-1:0]        z_hi;
  logic [BITS-1:0]        z_lo;
  logic                   res_err;

  modport slave (
    input  op_valid, opcode, a_in, b_in, alu_result, res_ready,
    output op_ready, alu_ctrl, alu_x, alu_y, res_valid, z_hi, z_lo, res_err
  );

  modport master (
    output op_valid, opcode, a_in, b_in, alu_result, res_ready,
    input  op_ready, alu_ctrl, alu_x, alu_y, res_valid, z_hi, z_lo, res_err
  );

endinterface

// File: rtl/alu_issue_ctrl_decoder.sv
// rtl/alu_issue_ctrl_decoder.sv - opcode to one-hot ALU control decoder
// Purpose: sets bit <opcode> of the output; all zero for opcodes outside the
//          legal range or beyond the control width.
// Ports:   opcode_i [3:0]            - ALU op index
//          onehot_o [SIG_COUNT-1:0]  - one-hot control, zero when illegal
module onehot_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int SIG_COUNT = 12
) (
  input  logic [3:0]           opcode_i,
  output logic [SIG_COUNT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < SIG_COUNT; i++) begin
      onehot_o[i] = (i < OP_COUNT) && (opcode_i == 4'(i));
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller sequencing one ALU operation at a time
// Purpose: accepts an operation in IDLE, drives registered operands and a
//          one-hot control to the ALU for 1 or MULDIV_LAT cycles, captures the
//          result and holds it until the consumer takes it. Illegal opcodes and
//          divide by zero skip the ALU and return an error result.
// Ports:   clk - clock, rising edge
//          clr - synchronous active-high reset
//          bus - alu_issue_ctrl_if slave modport (op handshake, ALU drive, result)
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = 12,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             clr,
  alu_issue_ctrl_if.slave  bus
);

  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT - 1);

  state_t                 state_q;
  logic [3:0]             count_q;
  logic [SIG_COUNT-1:0]   alu_ctrl_q;
  logic [BITS-1:0]        alu_x_q;
  logic [BITS-1:0]        alu_y_q;
  logic [BITS-1:0]        z_hi_q;
  logic [BITS-1:0]        z_lo_q;
  logic                   res_err_q;
  logic                   res_valid_q;
  logic                   op_ready_q;

  logic [SIG_COUNT-1:0]   alu_ctrl_d;
  logic [3:0]             count_d;
  logic                   legal_d;

  onehot_decoder #(.SIG_COUNT(SIG_COUNT)) u_dec (
    .opcode_i (bus.opcode),
    .onehot_o (alu_ctrl_d)
  );

  // An empty decode means illegal opcode; a zero divisor is trapped here so
  // the ALU never sees it.
  assign legal_d = (|alu_ctrl_d) && !((bus.opcode == OP_DIV) && (bus.b_in == '0));
  assign count_d = is_muldiv(bus.opcode) ? MULDIV_CNT : 4'd0;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      count_q     <= 4'd0;
      alu_ctrl_q  <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      z_hi_q      <= '0;
      z_lo_q      <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      op_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid && op_ready_q) begin
            op_ready_q <= 1'b0;
            if (legal_d) begin
              alu_x_q    <= bus.a_in;
              alu_y_q    <= bus.b_in;
              alu_ctrl_q <= alu_ctrl_d;
              count_q    <= count_d;
              state_q    <= ST_EXEC;
            end else begin
              z_hi_q      <= '0;
              z_lo_q      <= '0;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_EXEC: begin
          if (count_q == 4'd0) begin
            z_hi_q      <= bus.alu_result[2*BITS-1:BITS];
            z_lo_q      <= bus.alu_result[BITS-1:0];
            res_err_q   <= 1'b0;
            alu_ctrl_q  <= '0;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          alu_ctrl_q  <= '0;
          res_valid_q <= 1'b0;
          op_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.z_hi      = z_hi_q;
  assign bus.z_lo      = z_lo_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  localparam int BITS = 32;
  localparam int SIGS = 12;

  logic clk = 1'b0;
  logic clr;
  int   passed = 0;
  int   total  = 0;

  alu_issue_ctrl_if #(.BITS(BITS), .SIG_COUNT(SIGS)) bus ();

  alu_issue_ctrl #(.BITS(BITS), .SIG_COUNT(SIGS), .MULDIV_LAT(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational ALU model driven from the controller's registered outputs.
  always_comb begin
    bus.alu_result = '0;
    if (bus.alu_ctrl[0])      bus.alu_result = 64'(bus.alu_x) + 64'(bus.alu_y);
    else if (bus.alu_ctrl[1]) bus.alu_result = 64'(bus.alu_x) - 64'(bus.alu_y);
    else if (bus.alu_ctrl[2]) bus.alu_result = 64'(bus.alu_x) * 64'(bus.alu_y);
    else if (bus.alu_ctrl[3] && bus.alu_y != 0)
      bus.alu_result = {bus.alu_x % bus.alu_y, bus.alu_x / bus.alu_y};
    else if (bus.alu_ctrl[8]) bus.alu_result = 64'(bus.alu_x & bus.alu_y);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.opcode   = op;
    bus.a_in     = a;
    bus.b_in     = b;
    tick();
    bus.op_valid = 1'b0;
  endtask

  initial begin
    clr           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.opcode    = 4'd0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    clr = 1'b0;

    // reset state
    check("rst_op_ready", bus.op_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_alu_ctrl", bus.alu_ctrl, 0);
    check("rst_alu_x", bus.alu_x, 0);
    check("rst_z_lo", bus.z_lo, 0);
    check("rst_res_err", bus.res_err, 0);

    // add 5+7: one control cycle, result at T+2
    bus.res_ready = 1'b1;  // no effect while res_valid=0
    tick();
    bus.res_ready = 1'b0;
    check("idle_after_stray_ready", bus.op_ready, 1);
    issue(4'd0, 32'd5, 32'd7);
    check("add_ctrl", bus.alu_ctrl, 12'h001);
    check("add_x", bus.alu_x, 5);
    check("add_y", bus.alu_y, 7);
    check("add_busy", bus.op_ready, 0);
    check("add_no_valid_t1", bus.res_valid, 0);
    tick();
    check("add_ctrl_off", bus.alu_ctrl, 0);
    check("add_valid_t2", bus.res_valid, 1);
    check("add_z_hi", bus.z_hi, 0);
    check("add_z_lo", bus.z_lo, 12);
    check("add_err", bus.res_err, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("add_released", bus.res_valid, 0);
    check("add_idle", bus.op_ready, 1);

    // mul 0x10000*0x10000: control held T+1..T+4, result at T+5
    issue(4'd2, 32'h10000, 32'h10000);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("mul_ctrl_t%0d", i), bus.alu_ctrl, 12'h004);
      check($sformatf("mul_no_valid_t%0d", i), bus.res_valid, 0);
      tick();
    end
    check("mul_ctrl_off", bus.alu_ctrl, 0);
    check("mul_valid_t5", bus.res_valid, 1);
    check("mul_z_hi", bus.z_hi, 1);
    check("mul_z_lo", bus.z_lo, 0);
    check("mul_err", bus.res_err, 0);

    // backpressure: held result stable, second op ignored while in HOLD
    bus.op_valid = 1'b1;
    bus.opcode   = 4'd0;
    bus.a_in     = 32'd1;
    bus.b_in     = 32'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", bus.res_valid, 1);
      check("bp_z", {bus.z_hi, bus.z_lo}, 64'h1_0000_0000);
      check("bp_ready_low", bus.op_ready, 0);
      check("bp_ctrl", bus.alu_ctrl, 0);
    end
    check("bp_x_kept", bus.alu_x, 32'h10000);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_released", bus.res_valid, 0);
    check("bp_idle", bus.op_ready, 1);
    tick();  // op_valid still high: accepted now
    bus.op_valid = 1'b0;
    check("second_ctrl", bus.alu_ctrl, 12'h001);
    check("second_x", bus.alu_x, 1);
    check("second_y", bus.alu_y, 2);
    tick();
    check("second_valid", bus.res_valid, 1);
    check("second_z_lo", bus.z_lo, 3);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // divide by zero: error result at T+1, ALU untouched
    issue(4'd3, 32'd9, 32'd0);
    check("dz_valid_t1", bus.res_valid, 1);
    check("dz_err", bus.res_err, 1);
    check("dz_ctrl", bus.alu_ctrl, 0);
    check("dz_z", {bus.z_hi, bus.z_lo}, 0);
    check("dz_x_kept", bus.alu_x, 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // illegal opcode 13: same response
    issue(4'd13, 32'd4, 32'd4);
    check("ill_valid_t1", bus.res_valid, 1);
    check("ill_err", bus.res_err, 1);
    check("ill_ctrl", bus.alu_ctrl, 0);
    check("ill_z", {bus.z_hi, bus.z_lo}, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // div 100/7: four-cycle latency, quotient low, remainder high, error cleared
    issue(4'd3, 32'd100, 32'd7);
    check("div_ctrl", bus.alu_ctrl, 12'h008);
    tick();
    tick();
    tick();
    check("div_ctrl_t4", bus.alu_ctrl, 12'h008);
    tick();
    check("div_valid", bus.res_valid, 1);
    check("div_z_lo", bus.z_lo, 14);
    check("div_z_hi", bus.z_hi, 2);
    check("div_err", bus.res_err, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // reset mid-op: clr during T+2 of a mul aborts it
    issue(4'd2, 32'd3, 32'd4);
    tick();
    clr          = 1'b1;
    bus.op_valid = 1'b1;
    tick();
    clr          = 1'b0;
    bus.op_valid = 1'b0;
    check("abort_ctrl", bus.alu_ctrl, 0);
    check("abort_x", bus.alu_x, 0);
    check("abort_y", bus.alu_y, 0);
    check("abort_valid", bus.res_valid, 0);
    check("abort_ready", bus.op_ready, 1);
    check("abort_z", {bus.z_hi, bus.z_lo}, 0);
    check("abort_err", bus.res_err, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_result", bus.res_valid, 0);
    end

    // clr in IDLE with op_valid: no acceptance
    clr          = 1'b1;
    bus.op_valid = 1'b1;
    bus.opcode   = 4'd8;
    bus.a_in     = 32'hF0;
    bus.b_in     = 32'h3C;
    tick();
    clr          = 1'b0;
    bus.op_valid = 1'b0;
    check("clr_no_accept_ctrl", bus.alu_ctrl, 0);
    check("clr_no_accept_x", bus.alu_x, 0);
    check("clr_no_accept_ready", bus.op_ready, 1);

    // and after reset: still functional
    issue(4'd8, 32'hF0, 32'h3C);
    check("and_ctrl", bus.alu_ctrl, 12'h100);
    tick();
    check("and_valid", bus.res_valid, 1);
    check("and_z_lo", bus.z_lo, 32'h30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
